// File: rtl/fifo_pack_pkg.sv
// Shared types and helpers for the FIFO read-side byte packer.
package fifo_pack_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_BPW = 8;
    // Lane counter must hold 0..MAX_BPW plus one pending pop.
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {IDLE, FILL, HOLD} pack_state_t;

    // Byte-enable mask with ones in lanes 0..cnt-1.
    function automatic logic [MAX_BPW-1:0] ben_from_cnt(input logic [CNT_W-1:0] cnt);
        logic [MAX_BPW-1:0] ben;
        ben = '0;
        for (int k = 0; k < MAX_BPW; k++) begin
            if (k < int'(cnt)) ben[k] = 1'b1;
        end
        return ben;
    endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Idle counter for the packer's partial-word flush (used with PACK_TIMEOUT_EN).
// Counts enabled cycles, saturates at LIMIT-1 and holds 'done' there until cleared.
module pack_idle_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic rclk,
    input  logic reset_L,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q, count_d;

    // Clear has priority; count up while enabled, stop at the terminal value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) count_q <= '0;
        else          count_q <= count_d;
    end

    assign done = en && (count_q == LAST);

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops bytes, packs them little-endian into words and
// offers them on a valid/ready stream through a single output slot.
// Optional build macro: PACK_TIMEOUT_EN flushes a partial word after an idle period.
module fifo_rd_packer
    import fifo_pack_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                             rclk,
    input  logic                             reset_L,
    input  logic                             empty,
    input  logic [BYTE_W-1:0]                rdata,
    output logic                             pop,
    output logic                             out_valid,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] out_data,
    output logic [BYTES_PER_WORD-1:0]        out_ben,
    input  logic                             out_ready
);

    localparam int unsigned      WORD_W   = BYTE_W * BYTES_PER_WORD;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

    pack_state_t                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       pend_q;
    logic [WORD_W-1:0]          acc_q, acc_d, acc_cap;
    logic                       valid_q, valid_d;
    logic [WORD_W-1:0]          data_q, data_d;
    logic [BYTES_PER_WORD-1:0]  ben_q, ben_d;

    logic capture, slot_free, fill_xfer, hold_xfer, timeout_xfer, xfer;
    logic [CNT_W-1:0] commit;

    // rdata is valid exactly one cycle after a pop.
    assign capture   = pend_q;
    assign slot_free = !valid_q || out_ready;
    assign commit    = cnt_q + CNT_W'(pend_q);

    // Completing capture goes straight to the slot when it is free, so there is
    // no bubble at word boundaries; otherwise the word waits in HOLD.
    assign fill_xfer = capture && (cnt_q == CNT_LAST) && slot_free;
    assign hold_xfer = (state_q == HOLD) && slot_free;
    assign xfer      = fill_xfer || hold_xfer || timeout_xfer;

    // A lane freed by this cycle's transfer may already be committed to a new pop.
    // Gated by reset so the FIFO is never popped while held in reset.
    assign pop = reset_L && !empty && (state_q != HOLD) && ((commit < CNT_FULL) || fill_xfer);

`ifdef PACK_TIMEOUT_EN
    logic timer_done;

    pack_idle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .rclk    (rclk),
        .reset_L (reset_L),
        .clr     (capture || xfer),
        .en      ((state_q == FILL) && !pend_q),
        .done    (timer_done)
    );

    assign timeout_xfer = timer_done && slot_free;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_xfer       = 1'b0;
`endif

    // Accumulator with this cycle's captured byte inserted into lane cnt.
    always_comb begin
        acc_cap = acc_q;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (capture && (cnt_q == CNT_W'(k))) acc_cap[k*BYTE_W +: BYTE_W] = rdata;
        end
    end

    // Packing FSM and lane bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (xfer) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
            // A byte arriving alongside a HOLD/timeout transfer starts the next word.
            if (capture && !fill_xfer) begin
                acc_d[BYTE_W-1:0] = rdata;
                cnt_d             = CNT_W'(1);
                state_d           = FILL;
            end
        end else if (capture) begin
            acc_d   = acc_cap;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_LAST) ? HOLD : FILL;
        end
    end

    // Output slot: load on transfer, clear on handshake, otherwise hold steady.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ben_d   = ben_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = fill_xfer ? acc_cap : acc_q;
            ben_d   = BYTES_PER_WORD'(ben_from_cnt(timeout_xfer ? cnt_q : CNT_FULL));
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ben_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pop;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ben_q   <= ben_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ben   = ben_q;

endmodule
